display_scroller: RTL and testbench

- Upstream feeder for four active-low seven-segment digit decoders on the vending machine front panel.
- Produces four registered 4-bit display codes (hex3 leftmost, hex0 rightmost) from a mode select and a credit count.
- Scrolls an idle greeting, shows credit as a static two-digit value, flashes a dispense pattern, and shows an error pattern.
- Codes used are the decoder's symbol set:
  - digits 0,1,2,3,5,7,8 map to themselves
  - 4'h4 = L, 4'h6 = dash, 4'h9 = H, 4'hE = E, 4'hF = blank

---
 rtl/display_codes_pkg.sv | 38 +++
 rtl/display_scroller_tick_gen.sv | 37 +++
 rtl/display_scroller.sv | 119 +++++++++++
 tb/tb_display_scroller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/display_codes_pkg.sv
//------------------------------------------------------------------------------
// display_codes_pkg
// Symbol codes for the front-panel digit decoders, mode encodings and the
// idle greeting ROM shared by the display scroller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package display_codes_pkg;

    // Decoder symbol set: digits 0,1,2,3,5,7,8 map to themselves
    localparam logic [3:0] CODE_L     = 4'h4;
    localparam logic [3:0] CODE_DASH  = 4'h6;
    localparam logic [3:0] CODE_H     = 4'h9;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_CREDIT   = 2'd1,
        MODE_DISPENSE = 2'd2,
        MODE_ERROR    = 2'd3
    } mode_e;

    localparam int IDLE_MSG_LEN = 8;

    // "HELL0" followed by three blanks
    localparam logic [3:0] IDLE_MSG [IDLE_MSG_LEN] = '{
        CODE_H, CODE_E, CODE_L, CODE_L, 4'h0, CODE_BLANK, CODE_BLANK, CODE_BLANK
    };

    function automatic logic [3:0] msg_char(input logic [2:0] idx);
        return IDLE_MSG[idx];
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scroller_tick_gen.sv
//------------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// A synchronous clear restarts the count so a new mode gets a full period.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1, wrap, restart on clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scroller.sv
//------------------------------------------------------------------------------
// display_scroller
// Drives four 4-bit digit codes for the vending machine front panel:
// scrolling idle greeting, two-digit credit, flashing dispense dashes and
// a static error pattern. All outputs are registered.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module display_scroller
    import display_codes_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int MSG_LEN  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] mode,
    input  logic [2:0] credit,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic       msg_wrap
);

    localparam int OFS_W = $clog2(MSG_LEN);

    logic [1:0]       mode_q;
    logic [OFS_W-1:0] offset;
    logic             phase;

    logic             tick;
    logic             mode_change;
    logic [OFS_W-1:0] offset_d;
    logic             phase_d;
    logic             wrap_d;
    logic [15:0]      hex_d;
    mode_e            mode_sel;

    assign mode_sel    = mode_e'(mode);
    assign mode_change = (mode != mode_q);

    // The prescaler restarts on every mode change so the new mode starts
    // with a full tick period; a coincident tick is thereby discarded.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .clear  (mode_change),
        .tick   (tick)
    );

    // Next offset/phase and the pattern they select; the output register
    // loads the pattern of the next state so changes show one clock later
    always_comb begin
        offset_d = offset;
        phase_d  = phase;
        wrap_d   = 1'b0;
        hex_d    = {4{CODE_BLANK}};

        if (mode_change) begin
            offset_d = '0;
            phase_d  = 1'b0;
        end else if (tick) begin
            if (mode_sel == MODE_IDLE) begin
                offset_d = offset + OFS_W'(1);
                wrap_d   = (offset == OFS_W'(MSG_LEN - 1));
            end
            if (mode_sel == MODE_DISPENSE) begin
                phase_d = ~phase;
            end
        end

        case (mode_sel)
            MODE_IDLE: begin
                hex_d = {msg_char(offset_d),
                         msg_char(offset_d + OFS_W'(1)),
                         msg_char(offset_d + OFS_W'(2)),
                         msg_char(offset_d + OFS_W'(3))};
            end
            MODE_CREDIT: begin
                hex_d = {CODE_BLANK, CODE_BLANK,
                         {2'b00, credit[2:1]},
                         (credit[0] ? 4'd5 : 4'd0)};
            end
            MODE_DISPENSE: begin
                hex_d = phase_d ? {4{CODE_BLANK}} : {4{CODE_DASH}};
            end
            default: begin
                hex_d = {CODE_E, CODE_DASH, CODE_DASH, CODE_DASH};
            end
        endcase
    end

    // State and registered display outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q   <= MODE_IDLE;
            offset   <= '0;
            phase    <= 1'b0;
            msg_wrap <= 1'b0;
            hex3     <= CODE_BLANK;
            hex2     <= CODE_BLANK;
            hex1     <= CODE_BLANK;
            hex0     <= CODE_BLANK;
        end else begin
            mode_q   <= mode;
            offset   <= offset_d;
            phase    <= phase_d;
            msg_wrap <= wrap_d;
            {hex3, hex2, hex1, hex0} <= hex_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scroller.sv
//------------------------------------------------------------------------------
// tb_display_scroller
// Directed table-driven bench for display_scroller with TICK_DIV = 4.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_scroller;

    logic       clk;
    logic       resetn;
    logic [1:0] mode;
    logic [2:0] credit;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic       msg_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    display_scroller #(
        .TICK_DIV (4),
        .MSG_LEN  (8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mode     (mode),
        .credit   (credit),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .msg_wrap (msg_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  credit;
        int          cyc;
        logic [15:0] exp_hex;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            mode   = vecs[i].mode;
            credit = vecs[i].credit;
            repeat (vecs[i].cyc) @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d_hex", i), {hex3, hex2, hex1, hex0}, vecs[i].exp_hex);
            chk($sformatf("row%0d_wrap", i), {15'd0, msg_wrap}, {15'd0, vecs[i].exp_wrap});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;

        // IDLE scroll: one window per tick (4 clocks)
        vecs[0]  = '{2'd0, 3'd0, 1, 16'h9E44, 1'b0};
        vecs[1]  = '{2'd0, 3'd0, 3, 16'hE440, 1'b0};
        vecs[2]  = '{2'd0, 3'd0, 4, 16'h440F, 1'b0};
        vecs[3]  = '{2'd0, 3'd0, 4, 16'h40FF, 1'b0};
        vecs[4]  = '{2'd0, 3'd0, 4, 16'h0FFF, 1'b0};
        vecs[5]  = '{2'd0, 3'd0, 4, 16'hFFF9, 1'b0};
        vecs[6]  = '{2'd0, 3'd0, 4, 16'hFF9E, 1'b0};
        vecs[7]  = '{2'd0, 3'd0, 4, 16'hF9E4, 1'b0};
        vecs[8]  = '{2'd0, 3'd0, 4, 16'h9E44, 1'b1};
        vecs[9]  = '{2'd0, 3'd0, 1, 16'h9E44, 1'b0};
        // CREDIT
        vecs[10] = '{2'd1, 3'd0, 1, 16'hFF00, 1'b0};
        vecs[11] = '{2'd1, 3'd3, 1, 16'hFF15, 1'b0};
        vecs[12] = '{2'd1, 3'd7, 1, 16'hFF35, 1'b0};
        vecs[13] = '{2'd1, 3'd2, 1, 16'hFF10, 1'b0};
        vecs[14] = '{2'd1, 3'd5, 6, 16'hFF25, 1'b0};
        // DISPENSE flash
        vecs[15] = '{2'd2, 3'd5, 1, 16'h6666, 1'b0};
        vecs[16] = '{2'd2, 3'd5, 4, 16'hFFFF, 1'b0};
        vecs[17] = '{2'd2, 3'd5, 4, 16'h6666, 1'b0};
        // ERROR static
        vecs[18] = '{2'd3, 3'd5, 1, 16'hE666, 1'b0};
        vecs[19] = '{2'd3, 3'd5, 5, 16'hE666, 1'b0};
        // back to IDLE, offset cleared
        vecs[20] = '{2'd0, 3'd5, 1, 16'h9E44, 1'b0};

        mode   = 2'd0;
        credit = 3'd0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
        chk("reset_wrap", {15'd0, msg_wrap}, 16'd0);
        resetn = 1'b1;

        run_rows(0, 9);

        // A full 32-clock lap must produce exactly one wrap pulse
        wraps = 0;
        repeat (32) begin
            @(posedge clk);
            @(negedge clk);
            if (msg_wrap === 1'b1) wraps++;
        end
        chk("lap_wrap_count", 16'(wraps), 16'd1);
        chk("lap_window", {hex3, hex2, hex1, hex0}, 16'h9E44);

        run_rows(10, 20);

        // Switch to DISPENSE exactly in the tick cycle: tick is discarded
        repeat (3) @(posedge clk);
        @(negedge clk);
        mode = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("coinc_first", {hex3, hex2, hex1, hex0}, 16'h6666);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("coinc_hold", {hex3, hex2, hex1, hex0}, 16'h6666);
        @(posedge clk);
        @(negedge clk);
        chk("coinc_toggle", {hex3, hex2, hex1, hex0}, 16'hFFFF);
        mode = 2'd0;
        @(posedge clk);
        @(negedge clk);
        chk("coinc_back_idle", {hex3, hex2, hex1, hex0}, 16'h9E44);

        // Async reset mid-flash, asserted between clock edges
        mode = 2'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("preflash", {hex3, hex2, hex1, hex0}, 16'h6666);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
        mode = 2'd3;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("err_after_reset", {hex3, hex2, hex1, hex0}, 16'hE666);
        chk("err_wrap", {15'd0, msg_wrap}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
